// File: rtl/star_pkg.sv
// star_pkg: screen limits, star visibility codes, FSM states and box record shared by star logic.
package star_pkg;
   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] V_ACTIVE = 10'd480;
   // Star states 1, 2, 5 and 6 are the drawn ones.
   localparam logic [7:0] STAR_VIS_MASK = 8'b0110_0110;
   typedef enum logic [1:0] {PLAY, COOLDOWN, OVER} fsm_t;
   typedef struct packed {
      logic [9:0] left;
      logic [9:0] top;
      logic [9:0] width;
      logic [9:0] height;
   } box_t;
   function automatic logic star_visible(input logic [2:0] state);
      return STAR_VIS_MASK[state];
   endfunction
endpackage

// File: rtl/box_hit.sv
// box_hit: combinational pixel-in-box test, right/bottom edges summed at 11 bits and clipped to the screen.
module box_hit
   import star_pkg::*;
#(
   parameter logic [9:0] X_MAX = H_ACTIVE,
   parameter logic [9:0] Y_MAX = V_ACTIVE
) (
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  box_t       box,
   output logic       in_box
);
   logic [10:0] right, bottom;
   assign right  = {1'b0, box.left} + {1'b0, box.width};
   assign bottom = {1'b0, box.top} + {1'b0, box.height};
   assign in_box = (x >= box.left) && ({1'b0, x} < right) && (x < X_MAX) &&
                   (y >= box.top) && ({1'b0, y} < bottom) && (y < Y_MAX);
endmodule

// File: rtl/star_hit_detect.sv
// star_hit_detect: per-pixel star/player flags from frame-latched boxes, plus
// once-per-frame overlap detection driving the lives/cooldown FSM.
module star_hit_detect
   import star_pkg::*;
#(
   parameter logic [9:0] H_MAX           = H_ACTIVE,
   parameter logic [9:0] V_MAX           = V_ACTIVE,
   parameter int         COOLDOWN_FRAMES = 30,
   parameter int         LIVES_INIT      = 3,
   parameter int         CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0]       h_cnt,
   input  logic [9:0]       v_cnt,
   input  logic             frame_start,
   input  logic [9:0]       star_h,
   input  logic [9:0]       star_v,
   input  logic [9:0]       star_width,
   input  logic [9:0]       star_height,
   input  logic [2:0]       star_state,
   input  logic [9:0]       player_h,
   input  logic [9:0]       player_v,
   input  logic [9:0]       player_width,
   input  logic [9:0]       player_height,
   output logic             star_pixel,
   output logic             player_pixel,
   output logic             hit,
   output logic [1:0]       lives,
   output logic             game_over,
   output logic [CNT_W-1:0] hit_count
);
   box_t             star_q, star_d, player_q, player_d;
   logic             vis_q, vis_d;
   logic             star_in_box, player_in_box, star_on, overlap_now, overlap_frame;
   logic             star_pix_q, player_pix_q, overlap_q, overlap_d;
   logic             hit_q, hit_d;
   logic [1:0]       lives_q, lives_d;
   logic [7:0]       cd_q, cd_d;
   logic [CNT_W-1:0] hc_q, hc_d;
   fsm_t             state_q, state_d;

   box_hit #(.X_MAX(H_MAX), .Y_MAX(V_MAX)) u_star_box (
      .x(h_cnt), .y(v_cnt), .box(star_q), .in_box(star_in_box)
   );
   box_hit #(.X_MAX(H_MAX), .Y_MAX(V_MAX)) u_player_box (
      .x(h_cnt), .y(v_cnt), .box(player_q), .in_box(player_in_box)
   );

   assign star_on       = vis_q & star_in_box;
   assign overlap_now   = star_on & player_in_box;
   // An overlap on the frame_start cycle still belongs to the frame that is ending.
   assign overlap_frame = overlap_q | overlap_now;

   always_comb begin
      star_d    = frame_start ? '{star_h, star_v, star_width, star_height} : star_q;
      player_d  = frame_start ? '{player_h, player_v, player_width, player_height} : player_q;
      vis_d     = frame_start ? star_visible(star_state) : vis_q;
      overlap_d = frame_start ? 1'b0 : overlap_frame;
   end

   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      lives_d = lives_q;
      hc_d    = hc_q;
      hit_d   = 1'b0;
      if (frame_start) begin
         case (state_q)
            PLAY: if (overlap_frame) begin
               hit_d   = 1'b1;
               lives_d = lives_q - 2'd1;
               hc_d    = (hc_q == '1) ? hc_q : hc_q + 1'b1;
               cd_d    = 8'(COOLDOWN_FRAMES);
               state_d = (lives_d == 2'd0) ? OVER : COOLDOWN;
            end
            COOLDOWN: begin
               cd_d    = cd_q - 8'd1;
               state_d = (cd_d == 8'd0) ? PLAY : COOLDOWN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         star_q       <= '0;
         player_q     <= '0;
         vis_q        <= 1'b0;
         star_pix_q   <= 1'b0;
         player_pix_q <= 1'b0;
         overlap_q    <= 1'b0;
         hit_q        <= 1'b0;
         lives_q      <= 2'(LIVES_INIT);
         cd_q         <= '0;
         hc_q         <= '0;
         state_q      <= PLAY;
      end else begin
         star_q       <= star_d;
         player_q     <= player_d;
         vis_q        <= vis_d;
         star_pix_q   <= star_on;
         player_pix_q <= player_in_box;
         overlap_q    <= overlap_d;
         hit_q        <= hit_d;
         lives_q      <= lives_d;
         cd_q         <= cd_d;
         hc_q         <= hc_d;
         state_q      <= state_d;
      end
   end

   assign star_pixel   = star_pix_q;
   assign player_pixel = player_pix_q;
   assign hit          = hit_q;
   assign lives        = lives_q;
   assign hit_count    = hc_q;
   assign game_over    = (state_q == OVER);
endmodule

// File: tb/tb_star_hit_detect.sv
// tb_star_hit_detect: directed vectors with hand-computed expectations for star_hit_detect.
module tb_star_hit_detect;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] h_cnt = '0, v_cnt = '0;
   logic       frame_start = 1'b0;
   logic [9:0] star_h = '0, star_v = '0, star_width = '0, star_height = '0;
   logic [2:0] star_state = '0;
   logic [9:0] player_h = '0, player_v = '0, player_width = '0, player_height = '0;
   logic       star_pixel, player_pixel, hit, game_over;
   logic [1:0] lives;
   logic [7:0] hit_count;
   int         total = 0, bad = 0;
   int         first_hit, second_hit, nhits;

   always #5 clk = ~clk;

   star_hit_detect dut (
      .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_start(frame_start),
      .star_h(star_h), .star_v(star_v), .star_width(star_width), .star_height(star_height),
      .star_state(star_state), .player_h(player_h), .player_v(player_v),
      .player_width(player_width), .player_height(player_height),
      .star_pixel(star_pixel), .player_pixel(player_pixel), .hit(hit), .lives(lives),
      .game_over(game_over), .hit_count(hit_count)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input int h, input int v);
      h_cnt = 10'(h);
      v_cnt = 10'(v);
      tick;
   endtask

   task automatic fs_pulse;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
   endtask

   task automatic set_star(input int h, input int v, input int w, input int ht, input int s);
      star_h = 10'(h); star_v = 10'(v); star_width = 10'(w); star_height = 10'(ht);
      star_state = 3'(s);
   endtask

   task automatic set_player(input int h, input int v, input int w, input int ht);
      player_h = 10'(h); player_v = 10'(v); player_width = 10'(w); player_height = 10'(ht);
   endtask

   task automatic reset_pulse;
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      #12;
      chk("rst_star_pixel", star_pixel, 0);
      chk("rst_lives", lives, 3);
      chk("rst_hit_count", hit_count, 0);
      chk("rst_game_over", game_over, 0);
      chk("rst_hit", hit, 0);
      @(negedge clk);
      rst = 1'b1;

      // 1: star box edges, 1-cycle latency, no hit
      set_star(100, 60, 30, 30, 1);
      set_player(400, 300, 20, 20);
      pix(0, 0);
      fs_pulse;
      pix(99, 60);   chk("t1_left_out", star_pixel, 0);
      pix(100, 60);  chk("t1_left_in", star_pixel, 1);
      h_cnt = 10'd130;
      #1;            chk("t1_latency_hold", star_pixel, 1);
      tick;          chk("t1_right_out", star_pixel, 0);
      pix(129, 89);  chk("t1_corner_in", star_pixel, 1);
      pix(100, 90);  chk("t1_bottom_out", star_pixel, 0);
      pix(100, 59);  chk("t1_top_out", star_pixel, 0);
      pix(400, 300); chk("t1_player_in", player_pixel, 1);
      chk("t1_player_star_out", star_pixel, 0);
      fs_pulse;      chk("t1_no_hit", hit, 0);

      // 2: overlap in one frame -> hit after next frame_start
      set_star(100, 300, 30, 30, 2);
      set_player(110, 310, 20, 20);
      pix(0, 0);
      fs_pulse;      chk("t2_no_hit_latch", hit, 0);
      pix(115, 315); chk("t2_star_px", star_pixel, 1);
      chk("t2_player_px", player_pixel, 1);
      chk("t2_no_hit_yet", hit, 0);
      fs_pulse;      chk("t2_hit", hit, 1);
      chk("t2_lives", lives, 2);
      chk("t2_hit_count", hit_count, 1);
      tick;          chk("t2_hit_one_cycle", hit, 0);

      // 3: continuous overlap, hits 31 frames apart until game over
      first_hit = -1; second_hit = -1; nhits = 0;
      for (int f = 1; f <= 80; f++) begin
         frame_start = 1'b1;
         tick;
         if (hit) begin
            nhits++;
            if (first_hit < 0) first_hit = f;
            else if (second_hit < 0) second_hit = f;
         end
         frame_start = 1'b0;
         tick;
      end
      chk("t3_first_hit_frame", first_hit, 31);
      chk("t3_second_hit_frame", second_hit, 62);
      chk("t3_nhits", nhits, 2);
      chk("t3_lives", lives, 0);
      chk("t3_game_over", game_over, 1);
      chk("t3_hit_count", hit_count, 3);
      pix(115, 315); chk("t3_pixels_run", star_pixel, 1);

      // 4: hidden star and offscreen star
      reset_pulse;
      chk("t4_rst_lives", lives, 3);
      chk("t4_rst_game_over", game_over, 0);
      set_star(100, 300, 30, 30, 0);
      pix(0, 0);
      fs_pulse;
      pix(115, 315); chk("t4_hidden_star", star_pixel, 0);
      chk("t4_hidden_player", player_pixel, 1);
      fs_pulse;      chk("t4_hidden_no_hit", hit, 0);
      set_star(849, 300, 30, 30, 1);
      pix(0, 0);
      fs_pulse;
      pix(849, 300); chk("t4_off_849", star_pixel, 0);
      pix(639, 300); chk("t4_off_639", star_pixel, 0);
      chk("t4_lives_kept", lives, 3);

      // 5: clipping at right edge, overlap on the frame_start cycle itself
      set_star(620, 470, 30, 10, 5);
      set_player(639, 479, 1, 1);
      pix(0, 0);
      fs_pulse;
      pix(619, 475); chk("t5_clip_left_out", star_pixel, 0);
      pix(620, 475); chk("t5_clip_left_in", star_pixel, 1);
      pix(639, 475); chk("t5_clip_639", star_pixel, 1);
      pix(640, 475); chk("t5_clip_640", star_pixel, 0);
      chk("t5_no_hit_yet", hit, 0);
      h_cnt = 10'd639; v_cnt = 10'd479;
      fs_pulse;      chk("t5_edge_hit", hit, 1);
      chk("t5_edge_lives", lives, 2);
      chk("t5_edge_star_px", star_pixel, 1);

      // 6: async reset during cooldown, mid-line
      pix(630, 475);
      rst = 1'b0;
      #2;
      chk("t6_rst_lives", lives, 3);
      chk("t6_rst_hit_count", hit_count, 0);
      chk("t6_rst_game_over", game_over, 0);
      chk("t6_rst_star_px", star_pixel, 0);
      rst = 1'b1;
      pix(630, 475); chk("t6_shadow_cleared", star_pixel, 0);
      fs_pulse;
      pix(630, 475); chk("t6_resume_px", star_pixel, 1);
      pix(639, 479);
      pix(0, 0);
      fs_pulse;      chk("t6_resume_hit", hit, 1);
      chk("t6_resume_lives", lives, 2);
      chk("t6_resume_hit_count", hit_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
